// File: rtl/mm_cdr_acq_pkg.sv
// Shared types and default widths for the Mueller-Muller CDR acquisition sequencer.
// The optional relock-on-loss behaviour is selected in the top by MM_CDR_ACQ_RELOCK_EN.
package mm_cdr_acq_pkg;

  localparam int GAIN_W_DEF  = 5;
  localparam int PHASE_W_DEF = 10;
  localparam int DWELL_W_DEF = 16;
  localparam int LOCK_W_DEF  = 12;

  // Encodings are visible on the debug readback port, so they are pinned explicitly.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PHASE_ACQ = 3'd1,
    FREQ_ACQ  = 3'd2,
    GEAR      = 3'd3,
    TRACK     = 3'd4
  } acq_state_e;

endpackage

// File: rtl/mm_cdr_lock_det.sv
// Lock detector for the CDR phase estimate: modulo phase step against a reference,
// window compare, saturating qualification counter, lock flag and loss-of-lock pulse.
module mm_cdr_lock_det
  import mm_cdr_acq_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int LOCK_W  = LOCK_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               active,
  input  logic               clear,
  input  logic [PHASE_W-1:0] phase_est,
  input  logic [PHASE_W-2:0] lock_window,
  input  logic [LOCK_W-1:0]  lock_target,
  output logic               locked,
  output logic               lol,
  output logic               loss
);

  logic [PHASE_W-1:0] phase_ref;
  logic [PHASE_W-1:0] step;
  logic [PHASE_W-1:0] step_mag;
  logic [LOCK_W-1:0]  lock_cnt;
  logic [LOCK_W-1:0]  cnt_next;
  logic               in_window;

  // Wrapping subtraction makes a PI-code rollover look like a small step.
  assign step     = phase_est - phase_ref;
  assign step_mag = step[PHASE_W-1] ? (~step + PHASE_W'(1)) : step;
  assign in_window = (step_mag <= {1'b0, lock_window});

  assign cnt_next = (lock_cnt >= lock_target) ? lock_target : lock_cnt + LOCK_W'(1);

  // Loss is only a real event while qualifying in TRACK and not being torn down.
  assign loss = active && !clear && !in_window && locked;

  // NOTE: every register here uses <= so all updates see pre-edge values, like the hardware.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_ref <= '0;
      lock_cnt  <= '0;
      locked    <= 1'b0;
      lol       <= 1'b0;
    end else if (clear || !active) begin
      // Reference follows the estimate until TRACK, so it holds the entry value.
      phase_ref <= phase_est;
      lock_cnt  <= '0;
      locked    <= 1'b0;
      lol       <= 1'b0;
    end else if (in_window) begin
      lock_cnt <= cnt_next;
      if (cnt_next == lock_target) begin
        locked <= 1'b1;
      end
      lol <= 1'b0;
    end else begin
      phase_ref <= phase_est;
      lock_cnt  <= '0;
      locked    <= 1'b0;
      lol       <= locked;
    end
  end

endmodule

// File: rtl/mm_cdr_acq_ctrl.sv
// Acquisition and gain-scheduling sequencer for the Mueller-Muller CDR loop.
// Define MM_CDR_ACQ_RELOCK_EN to restart acquisition automatically on loss of lock.
module mm_cdr_acq_ctrl
  import mm_cdr_acq_pkg::*;
#(
  parameter int GAIN_W  = GAIN_W_DEF,
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF,
  parameter int LOCK_W  = LOCK_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [GAIN_W-1:0]  kp_acq,
  input  logic [GAIN_W-1:0]  ki_acq,
  input  logic [GAIN_W-1:0]  kp_trk,
  input  logic [GAIN_W-1:0]  ki_trk,
  input  logic [DWELL_W-1:0] dwell_cycles,
  input  logic [PHASE_W-2:0] lock_window,
  input  logic [LOCK_W-1:0]  lock_target,
  input  logic [PHASE_W-1:0] phase_est,
  output logic [GAIN_W-1:0]  kp,
  output logic [GAIN_W-1:0]  ki,
  output logic               en_freq_est,
  output logic               en_clamp,
  output logic               locked,
  output logic               lol,
  output logic [2:0]         state
);

`ifdef MM_CDR_ACQ_RELOCK_EN
  localparam bit RELOCK = 1'b1;
`else
  localparam bit RELOCK = 1'b0;
`endif

  acq_state_e         state_q, state_d;
  logic [GAIN_W-1:0]  kp_q, kp_d;
  logic [GAIN_W-1:0]  ki_q, ki_d;
  logic               frq_q, frq_d;
  logic               clamp_q, clamp_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] dwell_load;
  logic               dwell_exp;
  logic               loss_evt;

  // A zero dwell setting behaves as a one-cycle dwell.
  assign dwell_load = (dwell_cycles == '0) ? '0 : dwell_cycles - DWELL_W'(1);
  assign dwell_exp  = (dwell_q == '0);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    kp_d    = kp_q;
    ki_d    = ki_q;
    frq_d   = frq_q;
    clamp_d = clamp_q;
    dwell_d = dwell_q;

    if (!en) begin
      state_d = IDLE;
      kp_d    = '0;
      ki_d    = '0;
      frq_d   = 1'b0;
      clamp_d = 1'b0;
      dwell_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = PHASE_ACQ;
          kp_d    = kp_acq;
          ki_d    = '0;
          frq_d   = 1'b0;
          clamp_d = 1'b1;
          dwell_d = dwell_load;
        end
        PHASE_ACQ: begin
          if (dwell_exp) begin
            state_d = FREQ_ACQ;
            ki_d    = ki_acq;
            frq_d   = 1'b1;
            clamp_d = 1'b1;
            dwell_d = dwell_load;
          end else begin
            dwell_d = dwell_q - DWELL_W'(1);
          end
        end
        FREQ_ACQ: begin
          if (dwell_exp) begin
            state_d = GEAR;
            // Gains below target jump straight to it; the schedule only steps down.
            if (kp_q < kp_trk) kp_d = kp_trk;
            if (ki_q < ki_trk) ki_d = ki_trk;
            dwell_d = dwell_load;
          end else begin
            dwell_d = dwell_q - DWELL_W'(1);
          end
        end
        GEAR: begin
          if (dwell_exp) begin
            if (kp_q == kp_trk && ki_q == ki_trk) begin
              state_d = TRACK;
              frq_d   = 1'b1;
              clamp_d = 1'b0;
            end else begin
              kp_d = (kp_q > kp_trk) ? kp_q - GAIN_W'(1) : kp_trk;
              ki_d = (ki_q > ki_trk) ? ki_q - GAIN_W'(1) : ki_trk;
            end
            dwell_d = dwell_load;
          end else begin
            dwell_d = dwell_q - DWELL_W'(1);
          end
        end
        TRACK: begin
          kp_d = kp_trk;
          ki_d = ki_trk;
          if (RELOCK && loss_evt) begin
            state_d = PHASE_ACQ;
            kp_d    = kp_acq;
            ki_d    = '0;
            frq_d   = 1'b0;
            clamp_d = 1'b1;
            dwell_d = dwell_load;
          end
        end
        default: begin
          state_d = IDLE;
          kp_d    = '0;
          ki_d    = '0;
          frq_d   = 1'b0;
          clamp_d = 1'b0;
          dwell_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      kp_q    <= '0;
      ki_q    <= '0;
      frq_q   <= 1'b0;
      clamp_q <= 1'b0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      kp_q    <= kp_d;
      ki_q    <= ki_d;
      frq_q   <= frq_d;
      clamp_q <= clamp_d;
      dwell_q <= dwell_d;
    end
  end

  // Disabling tears down TRACK without flagging it as a loss of lock.
  mm_cdr_lock_det #(
    .PHASE_W (PHASE_W),
    .LOCK_W  (LOCK_W)
  ) u_lock_det (
    .clk         (clk),
    .rst         (rst),
    .active      (state_q == TRACK),
    .clear       (!en),
    .phase_est   (phase_est),
    .lock_window (lock_window),
    .lock_target (lock_target),
    .locked      (locked),
    .lol         (lol),
    .loss        (loss_evt)
  );

  assign kp          = kp_q;
  assign ki          = ki_q;
  assign en_freq_est = frq_q;
  assign en_clamp    = clamp_q;
  assign state       = state_q;

endmodule

// File: tb/tb_mm_cdr_acq_ctrl.sv
// Table-driven bench for mm_cdr_acq_ctrl: each row sets inputs for one edge and
// lists the registered outputs expected right after that edge.
module tb_mm_cdr_acq_ctrl;
  import mm_cdr_acq_pkg::*;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [4:0]  kp_acq, ki_acq, kp_trk, ki_trk;
  logic [15:0] dwell_cycles;
  logic [8:0]  lock_window;
  logic [11:0] lock_target;
  logic [9:0]  phase_est;
  logic [4:0]  kp, ki;
  logic        en_freq_est, en_clamp, locked, lol;
  logic [2:0]  state;

  always #5 clk = ~clk;

  mm_cdr_acq_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .kp_acq       (kp_acq),
    .ki_acq       (ki_acq),
    .kp_trk       (kp_trk),
    .ki_trk       (ki_trk),
    .dwell_cycles (dwell_cycles),
    .lock_window  (lock_window),
    .lock_target  (lock_target),
    .phase_est    (phase_est),
    .kp           (kp),
    .ki           (ki),
    .en_freq_est  (en_freq_est),
    .en_clamp     (en_clamp),
    .locked       (locked),
    .lol          (lol),
    .state        (state)
  );

  typedef struct {
    int    rst, en, ph, dwell, kpa, kpt, tgt;
    int    st, kp, ki, frq, clamp, lk, lo;
    string nm;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Configuration captured into each row as it is added.
  int c_ph, c_dwell, c_kpa, c_kpt, c_tgt;

  task automatic add(input int r, input int e, input int st, input int k_p, input int k_i,
                     input int f, input int c, input int lk, input int lo, input string nm);
    vec_t v;
    v.rst = r; v.en = e; v.ph = c_ph; v.dwell = c_dwell; v.kpa = c_kpa; v.kpt = c_kpt;
    v.tgt = c_tgt; v.st = st; v.kp = k_p; v.ki = k_i; v.frq = f; v.clamp = c;
    v.lk = lk; v.lo = lo; v.nm = nm;
    vecs.push_back(v);
  endtask

  // Expected trace for dwell=4, kp 6->3, ki 8->4, counted in edges after en rises.
  task automatic add_main_trace(input int upto);
    for (int e = 1; e <= upto; e++) begin
      if (e <= 4)       add(0, 1, int'(PHASE_ACQ), 6, 0, 0, 1, 0, 0, "acq_phase");
      else if (e <= 8)  add(0, 1, int'(FREQ_ACQ), 6, 8, 1, 1, 0, 0, "acq_freq");
      else if (e <= 28) begin
        int g;
        g = (e - 9) / 4;
        add(0, 1, int'(GEAR), (g < 3) ? 6 - g : 3, 8 - g, 1, 1, 0, 0, "acq_gear");
      end else          add(0, 1, int'(TRACK), 3, 4, 1, 0, 0, 0, "acq_track");
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  initial begin
    ki_acq = 5'd8; ki_trk = 5'd4; lock_window = 9'd2;
    rst = 1'b1; en = 1'b0; phase_est = '0; dwell_cycles = '0;
    kp_acq = '0; kp_trk = '0; lock_target = '0;

    // Main acquisition, wrap-around lock qualification, loss of lock.
    c_ph = 1023; c_dwell = 4; c_kpa = 6; c_kpt = 3; c_tgt = 5;
    add(1, 0, int'(IDLE), 0, 0, 0, 0, 0, 0, "reset");
    add_main_trace(29);
    c_ph = 1022; add(0, 1, int'(TRACK), 3, 4, 1, 0, 0, 0, "lock_q1");
    c_ph = 1023; add(0, 1, int'(TRACK), 3, 4, 1, 0, 0, 0, "lock_q2");
    c_ph = 0;    add(0, 1, int'(TRACK), 3, 4, 1, 0, 0, 0, "lock_wrap");
    c_ph = 1;    add(0, 1, int'(TRACK), 3, 4, 1, 0, 0, 0, "lock_edge");
    c_ph = 0;    add(0, 1, int'(TRACK), 3, 4, 1, 0, 1, 0, "lock_set");
    c_ph = 1;    add(0, 1, int'(TRACK), 3, 4, 1, 0, 1, 0, "lock_hold");
    c_ph = 99;
`ifdef MM_CDR_ACQ_RELOCK_EN
    add(0, 1, int'(PHASE_ACQ), 6, 0, 0, 1, 0, 1, "lol_pulse");
    add(0, 1, int'(PHASE_ACQ), 6, 0, 0, 1, 0, 0, "lol_end");
`else
    add(0, 1, int'(TRACK), 3, 4, 1, 0, 0, 1, "lol_pulse");
    add(0, 1, int'(TRACK), 3, 4, 1, 0, 0, 0, "lol_end");
`endif

    // Reset in the middle of GEAR with kp=3 (rst dominates en).
    c_ph = 1023;
    add(1, 0, int'(IDLE), 0, 0, 0, 0, 0, 0, "reset2");
    add_main_trace(21);
    add(1, 1, int'(IDLE), 0, 0, 0, 0, 0, 0, "rst_mid_gear");

    // Zero dwell: every step lasts a single cycle.
    c_dwell = 0;
    add(0, 0, int'(IDLE), 0, 0, 0, 0, 0, 0, "idle");
    add(0, 1, int'(PHASE_ACQ), 6, 0, 0, 1, 0, 0, "d0_phase");
    add(0, 1, int'(FREQ_ACQ), 6, 8, 1, 1, 0, 0, "d0_freq");
    add(0, 1, int'(GEAR), 6, 8, 1, 1, 0, 0, "d0_gear0");
    add(0, 1, int'(GEAR), 5, 7, 1, 1, 0, 0, "d0_gear1");
    add(0, 1, int'(GEAR), 4, 6, 1, 1, 0, 0, "d0_gear2");
    add(0, 1, int'(GEAR), 3, 5, 1, 1, 0, 0, "d0_gear3");
    add(0, 1, int'(GEAR), 3, 4, 1, 1, 0, 0, "d0_gear4");
    add(0, 1, int'(TRACK), 3, 4, 1, 0, 0, 0, "d0_track");

    // kp_acq below kp_trk, lock_target=0, then disable while locked.
    c_kpa = 2; c_kpt = 4; c_tgt = 0; c_ph = 500;
    add(1, 0, int'(IDLE), 0, 0, 0, 0, 0, 0, "reset3");
    add(0, 1, int'(PHASE_ACQ), 2, 0, 0, 1, 0, 0, "up_phase");
    add(0, 1, int'(FREQ_ACQ), 2, 8, 1, 1, 0, 0, "up_freq");
    add(0, 1, int'(GEAR), 4, 8, 1, 1, 0, 0, "up_gear_entry");
    add(0, 1, int'(GEAR), 4, 7, 1, 1, 0, 0, "up_gear1");
    add(0, 1, int'(GEAR), 4, 6, 1, 1, 0, 0, "up_gear2");
    add(0, 1, int'(GEAR), 4, 5, 1, 1, 0, 0, "up_gear3");
    add(0, 1, int'(GEAR), 4, 4, 1, 1, 0, 0, "up_gear4");
    add(0, 1, int'(TRACK), 4, 4, 1, 0, 0, 0, "up_track");
    add(0, 1, int'(TRACK), 4, 4, 1, 0, 1, 0, "tgt0_lock");
    c_ph = 600;
    add(0, 0, int'(IDLE), 0, 0, 0, 0, 0, 0, "disable_no_lol");

    foreach (vecs[i]) begin
      rst          = (vecs[i].rst != 0);
      en           = (vecs[i].en != 0);
      phase_est    = 10'(vecs[i].ph);
      dwell_cycles = 16'(vecs[i].dwell);
      kp_acq       = 5'(vecs[i].kpa);
      kp_trk       = 5'(vecs[i].kpt);
      lock_target  = 12'(vecs[i].tgt);
      @(posedge clk);
      #1;
      check($sformatf("%s[%0d].state", vecs[i].nm, i), 32'(state), vecs[i].st);
      check($sformatf("%s[%0d].kp", vecs[i].nm, i), 32'(kp), vecs[i].kp);
      check($sformatf("%s[%0d].ki", vecs[i].nm, i), 32'(ki), vecs[i].ki);
      check($sformatf("%s[%0d].en_freq_est", vecs[i].nm, i), 32'(en_freq_est), vecs[i].frq);
      check($sformatf("%s[%0d].en_clamp", vecs[i].nm, i), 32'(en_clamp), vecs[i].clamp);
      check($sformatf("%s[%0d].locked", vecs[i].nm, i), 32'(locked), vecs[i].lk);
      check($sformatf("%s[%0d].lol", vecs[i].nm, i), 32'(lol), vecs[i].lo);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
